acc_cpu_mc: RTL and testbench
=============================

# acc_cpu_mc

Parametrised multi-cycle accumulator CPU core, the next generation of the team's single-cycle accumulator machine. Data and address widths are generic, and Z and C flags drive conditional branches. Instruction and data memories sit outside the core behind separate req/ack handshake ports, so wait-state memories can be attached. The core is the top-level processing element; testbenches and SoC wrappers attach the memories.

## Interface
- DATA_W, 16, accumulator and data-memory word width; must be ≥ ADDR_W.
- ADDR_W, 12, instruction and data address width; instruction width is 4+ADDR_W.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- imem_req  out  1  instruction fetch request; high only in FETCH.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  4+ADDR_W  instruction: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand.
- imem_ack  in  1  fetch data valid; sampled only while imem_req high.
- dmem_req  out  1  data access request; high only in MEM.
- dmem_we  out  1  1 = write (STA), 0 = read.
- dmem_addr  out  ADDR_W  operand address from ir.
- dmem_wdata  out  DATA_W  accumulator value.
- dmem_rdata  in  DATA_W  read data.
- dmem_ack  in  1  access complete; sampled only while dmem_req high.
- acc_out  out  DATA_W  accumulator.
- pc_out  out  ADDR_W  program counter.
- flag_z, flag_c  out  1 each  zero and carry flags.
- halted  out  1  high in HALT.

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR, A JMP, B JZ, C JC, D LDI, E NOT, F HLT.
  - Memory operand: LDA, ADD–XOR.
  - Memory destination: STA.
  - All others use no memory.
- States: BOOT, FETCH, EXEC, MEM, HALT.
- BOOT → FETCH unconditionally.
- FETCH: imem_req=1. On imem_ack: ir←imem_rdata, → EXEC. Otherwise hold.
- EXEC:
  - Memory opcodes → MEM.
  - NOP, SHL, SHR, NOT, LDI, JMP, JZ, JC → FETCH.
  - HLT → HALT.
- MEM: dmem_req=1, dmem_we=(op==STA). On dmem_ack: result written, → FETCH. Otherwise hold with all dmem outputs stable.
- HALT: absorbing until rst. No requests are issued, and no state changes.
- Accumulator update (at completion):
  - LDA: acc←rdata.
  - ADD: {C,acc}←acc+rdata (DATA_W+1 bits).
  - SUB: acc←acc−rdata; C←1 iff acc<rdata unsigned (borrow).
  - AND/OR/XOR: bitwise with rdata; C unchanged.
  - SHL: C←acc[MSB], acc←acc<<1.
  - SHR: C←acc[0], acc←acc>>1 (logical).
  - NOT: acc←~acc; C unchanged.
  - LDI: acc←zero-extended operand.
- Z←(new acc==0) on every acc write. STA, NOP, jumps and HLT leave acc, Z and C unchanged.
- PC:
  - Default pc←pc+1 at instruction completion, wrapping modulo 2^ADDR_W.
  - JMP: pc←operand.
  - JZ: pc←operand if Z, else pc+1.
  - JC: pc←operand if C, else pc+1.
  - HLT: pc is not incremented; pc_out shows the HLT address.

## Timing
- Reset values: state=BOOT, pc=0, acc=0, ir=0, Z=0, C=0, halted=0. All req and we low.
  - imem_addr=0, dmem_addr=0, dmem_wdata=0.
- First imem_req is in the first cycle after BOOT, i.e. the second clock after rst release.
- With zero-wait memories (ack in the same cycle as req):
  - Non-memory instruction = 2 cycles (FETCH, EXEC).
  - Memory instruction = 3 cycles.
- Each wait cycle extends FETCH or MEM by one cycle.
- A request is held, with address and data unchanged, until ack. Acks while req is low are ignored.
- pc, acc and flags update on the clock edge that ends EXEC (non-memory ops) or MEM (on dmem_ack). The new value is visible the next cycle.
- rst mid-FETCH or mid-MEM abandons the access immediately: req drops asynchronously, and a pending STA is not committed by the core.
- Jump to the current pc is legal and spins.
- LDI operand wider than needed is impossible, since DATA_W ≥ ADDR_W.

## Structure
- Package acc_cpu_pkg holds:
  - the opcode localparams (4-bit);
  - the state enum (BOOT, FETCH, EXEC, MEM, HALT);
  - a function decoding "uses memory operand" from the opcode.
- One combinational sub-module, acc_alu: inputs op, a, b, c_in; outputs result[DATA_W-1:0], c_out, z.
- FSM, pc, ir, acc and flags live in acc_cpu_mc.

## Test plan
- Reset, then LDI 5; ADD [0x010] with mem[0x010]=7; STA [0x011]; HLT, zero-wait memory → mem[0x011]=12.
  - halted=1 after 2+3+3+2 cycles from the first FETCH.
  - pc_out=3.
- DATA_W=8: LDI 0xFF; ADD [x] with mem[x]=1 → acc=0, C=1, Z=1. Then JC 0x20 → pc=0x20.
- SUB borrow: LDI 3; SUB [y] with mem[y]=5 → acc=0xFFFE (16-bit), C=1, Z=0. Then JZ 0x40 is not taken, so pc increments.
- Wait states: imem_ack delayed 3 cycles, dmem_ack delayed 2 cycles.
  - imem_addr, dmem_addr and dmem_wdata stay stable while req is high.
  - A spurious ack with req low has no effect.
  - Final memory contents match the zero-wait run.
- rst asserted during the MEM of an STA → dmem_req drops the same cycle.
  - After release: pc=0, acc=0, and BOOT precedes FETCH.
- Wrap: ADDR_W=4, program filled with NOP → pc runs 15→0 and fetch continues. SHL/SHR on 0x8001 give the correct C and acc.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM states and decode helpers
// for the multi-cycle accumulator core.
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_JZ  = 4'hB;
  localparam logic [3:0] OP_JC  = 4'hC;
  localparam logic [3:0] OP_LDI = 4'hD;
  localparam logic [3:0] OP_NOT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  function automatic logic mem_operand(logic [3:0] op);
    return (op == OP_LDA) ||
           (op >= OP_ADD && op <= OP_XOR);
  endfunction

  function automatic logic needs_mem(logic [3:0] op);
    return mem_operand(op) || (op == OP_STA);
  endfunction

  // Ops that write acc directly in EXEC
  function automatic logic exec_acc(logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) ||
           (op == OP_NOT) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: result, carry
// and zero for every acc-writing opcode.
module acc_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              c_in,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z
);

  always_comb begin
    result = a;
    c_out  = c_in;
    unique case (op)
      OP_LDA: result = b;
      OP_ADD: {c_out, result} = {1'b0, a} + {1'b0, b};
      // Top bit of the widened difference is the borrow
      OP_SUB: {c_out, result} = {1'b0, a} - {1'b0, b};
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        c_out  = a[DATA_W-1];
        result = a << 1;
      end
      OP_SHR: begin
        c_out  = a[0];
        result = a >> 1;
      end
      OP_NOT: result = ~a;
      OP_LDI: result = b;
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/acc_cpu_mc.sv
// Multi-cycle accumulator core with req/ack
// instruction and data memory ports.
module acc_cpu_mc
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W+3:0] imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flag_z,
  output logic              flag_c,
  output logic              halted
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [ADDR_W+3:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                z_q, z_d, c_q, c_d;
  logic [3:0]          op;
  logic [ADDR_W-1:0]   opd;
  logic [DATA_W-1:0]   alu_b, alu_res;
  logic                alu_c, alu_z;
  logic                acc_we, jump;

  assign op     = ir_q[ADDR_W+3:ADDR_W];
  assign opd    = ir_q[ADDR_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign alu_b  = (op == OP_LDI) ? DATA_W'(opd)
                                 : dmem_rdata;

  acc_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (acc_q),
    .b      (alu_b),
    .c_in   (c_q),
    .result (alu_res),
    .c_out  (alu_c),
    .z      (alu_z)
  );

  assign acc_we =
    (state_q == S_EXEC && exec_acc(op)) ||
    (state_q == S_MEM && dmem_ack && op != OP_STA);

  assign jump = (op == OP_JMP) ||
                (op == OP_JZ && z_q) ||
                (op == OP_JC && c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (imem_ack) state_d = S_EXEC;
      S_EXEC: begin
        if (needs_mem(op))      state_d = S_MEM;
        else if (op == OP_HLT)  state_d = S_HALT;
        else                    state_d = S_FETCH;
      end
      S_MEM:   if (dmem_ack) state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_STA);
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;
    if (state_q == S_FETCH && imem_ack)
      ir_d = imem_rdata;
    if (acc_we) begin
      acc_d = alu_res;
      z_d   = alu_z;
      c_d   = alu_c;
    end
    // HLT leaves pc on its own address
    if (state_q == S_EXEC && !needs_mem(op) &&
        op != OP_HLT)
      pc_d = jump ? opd : pc_inc;
    if (state_q == S_MEM && dmem_ack)
      pc_d = pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = opd;
  assign dmem_wdata = acc_q;
  assign acc_out    = acc_q;
  assign pc_out     = pc_q;
  assign flag_z     = z_q;
  assign flag_c     = c_q;

endmodule

// File: tb/tb_acc_cpu_mc.sv
// Bench for acc_cpu_mc: directed programs plus random
// programs checked against an ISA-level model.
module tb_acc_cpu_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: 16/12, bench-driven wait states
  logic        ireq_a, ia, dreq_a, dwe_a, da;
  logic [11:0] iaddr_a, daddr_a, pc_a;
  logic [15:0] ird_a, dwd_a, drd_a, acc_a;
  logic        z_a, c_a, halt_a;
  logic [15:0] im_a [4096];
  logic [15:0] dm_a [4096];
  logic [15:0] mm   [4096];
  assign ird_a = im_a[iaddr_a];
  assign drd_a = dm_a[daddr_a];

  acc_cpu_mc #(.DATA_W(16), .ADDR_W(12)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req(ireq_a), .imem_addr(iaddr_a),
    .imem_rdata(ird_a), .imem_ack(ia),
    .dmem_req(dreq_a), .dmem_we(dwe_a),
    .dmem_addr(daddr_a), .dmem_wdata(dwd_a),
    .dmem_rdata(drd_a), .dmem_ack(da),
    .acc_out(acc_a), .pc_out(pc_a),
    .flag_z(z_a), .flag_c(c_a), .halted(halt_a)
  );

  // Instance B: 8-bit data, zero-wait
  logic       ireq_b, dreq_b, dwe_b, z_b, c_b, halt_b;
  logic [7:0] iaddr_b, daddr_b, pc_b, dwd_b, drd_b, acc_b;
  logic [11:0] ird_b;
  logic [11:0] im_b [256];
  logic [7:0]  dm_b [256];
  assign ird_b = im_b[iaddr_b];
  assign drd_b = dm_b[daddr_b];

  acc_cpu_mc #(.DATA_W(8), .ADDR_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(ireq_b), .imem_addr(iaddr_b),
    .imem_rdata(ird_b), .imem_ack(ireq_b),
    .dmem_req(dreq_b), .dmem_we(dwe_b),
    .dmem_addr(daddr_b), .dmem_wdata(dwd_b),
    .dmem_rdata(drd_b), .dmem_ack(dreq_b),
    .acc_out(acc_b), .pc_out(pc_b),
    .flag_z(z_b), .flag_c(c_b), .halted(halt_b)
  );

  // Instance C: 4-bit address, all-NOP program
  logic        ireq_c, dreq_c, dwe_c, z_c, c_c, halt_c;
  logic [3:0]  iaddr_c, daddr_c, pc_c;
  logic [15:0] dwd_c, acc_c;
  logic [7:0]  ird_c;
  logic [15:0] drd_c;
  assign ird_c = 8'h00;
  assign drd_c = 16'h0000;

  acc_cpu_mc #(.DATA_W(16), .ADDR_W(4)) dut_c (
    .clk(clk), .rst(rst),
    .imem_req(ireq_c), .imem_addr(iaddr_c),
    .imem_rdata(ird_c), .imem_ack(ireq_c),
    .dmem_req(dreq_c), .dmem_we(dwe_c),
    .dmem_addr(daddr_c), .dmem_wdata(dwd_c),
    .dmem_rdata(drd_c), .dmem_ack(dreq_c),
    .acc_out(acc_c), .pc_out(pc_c),
    .flag_z(z_c), .flag_c(c_c), .halted(halt_c)
  );

  int iwait, dwait, spur, icnt, dcnt, viol;
  logic        pireq, pdreq;
  logic [11:0] piaddr;
  logic [28:0] pdv;

  task automatic clear_a();
    for (int i = 0; i < 4096; i++) begin
      im_a[i] = 16'hF000;
      dm_a[i] = 16'h0000;
    end
  endtask

  // One clock of the A-side memory: stability watch,
  // ack timing, spurious acks, and the STA commit.
  task automatic cycle_a();
    @(negedge clk);
    if (ireq_a && pireq && iaddr_a !== piaddr) viol++;
    if (dreq_a && pdreq &&
        {daddr_a, dwe_a, dwd_a} !== pdv) viol++;
    pireq  = ireq_a;
    piaddr = iaddr_a;
    pdreq  = dreq_a;
    pdv    = {daddr_a, dwe_a, dwd_a};
    if (ireq_a) begin
      if (icnt >= iwait) ia = 1'b1;
      else begin ia = 1'b0; icnt++; end
    end else begin
      icnt = 0;
      ia = (spur != 0) && ($urandom % 2 == 1);
    end
    if (dreq_a) begin
      if (dcnt >= dwait) da = 1'b1;
      else begin da = 1'b0; dcnt++; end
    end else begin
      dcnt = 0;
      da = (spur != 0) && ($urandom % 2 == 1);
    end
    if (dreq_a && da && dwe_a) dm_a[daddr_a] = dwd_a;
  endtask

  task automatic start_a(input int iw, input int dw,
                         input int sp);
    iwait = iw; dwait = dw; spur = sp;
    rst = 1'b1; ia = 1'b0; da = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    viol = 0; icnt = 0; dcnt = 0;
    pireq = 1'b0; pdreq = 1'b0;
    piaddr = '0; pdv = '0;
  endtask

  task automatic run_a(input int iw, input int dw,
                       input int sp, input int maxc,
                       output int cyc);
    start_a(iw, dw, sp);
    cyc = 0;
    while (!halt_a && cyc <= maxc) begin
      cycle_a();
      cyc++;
    end
  endtask

  // ISA-level reference: instruction semantics and
  // cycle cost straight from the instruction set.
  task automatic model_run(input int iw, input int dw,
                           output logic [15:0] macc,
                           output logic [11:0] mpc,
                           output logic mz, output logic mc,
                           output int mcyc);
    logic [15:0] ins, m;
    logic [3:0]  op;
    logic [11:0] opd;
    logic [16:0] s;
    macc = '0; mpc = '0; mz = 1'b0; mc = 1'b0;
    mcyc = 1;
    for (int n = 0; n < 2000; n++) begin
      ins = im_a[mpc];
      op  = ins[15:12];
      opd = ins[11:0];
      m   = mm[opd];
      if (op >= 4'h1 && op <= 4'h7) mcyc += 3 + iw + dw;
      else mcyc += 2 + iw;
      if (op == 4'hF) break;
      case (op)
        4'h1: macc = m;
        4'h2: mm[opd] = macc;
        4'h3: begin
          s = {1'b0, macc} + {1'b0, m};
          macc = s[15:0]; mc = s[16];
        end
        4'h4: begin mc = (macc < m); macc = macc - m; end
        4'h5: macc = macc & m;
        4'h6: macc = macc | m;
        4'h7: macc = macc ^ m;
        4'h8: begin mc = macc[15]; macc = macc << 1; end
        4'h9: begin mc = macc[0]; macc = macc >> 1; end
        4'hD: macc = {4'h0, opd};
        4'hE: macc = ~macc;
        default: ;
      endcase
      if (op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                     4'h8, 4'h9, 4'hD, 4'hE})
        mz = (macc == 16'h0000);
      if (op == 4'hA || (op == 4'hB && mz) ||
          (op == 4'hC && mc))
        mpc = opd;
      else
        mpc = mpc + 12'd1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ia = 1'b0; da = 1'b0;
    clear_a();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({ireq_a, dreq_a, dwe_a, halt_a} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {ireq_a, dreq_a, dwe_a, halt_a});
    end
    tests++;
    if ({iaddr_a, daddr_a, dwd_a} !== 40'h0) begin
      fails++;
      $display("FAIL reset_bus: got %h want 0",
               {iaddr_a, daddr_a, dwd_a});
    end
    tests++;
    if ({acc_a, pc_a, z_a, c_a} !== 30'h0) begin
      fails++;
      $display("FAIL reset_state: got %h want 0",
               {acc_a, pc_a, z_a, c_a});
    end
    iwait = 0; dwait = 0; spur = 0;
    icnt = 0; dcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (ireq_a !== 1'b0) begin
      fails++;
      $display("FAIL boot_no_req: got %b want 0", ireq_a);
    end
    cycle_a();
    tests++;
    if (ireq_a !== 1'b1) begin
      fails++;
      $display("FAIL first_fetch: got %b want 1", ireq_a);
    end
  endtask

  task automatic load_basic();
    clear_a();
    im_a[0] = 16'hD005;
    im_a[1] = 16'h3010;
    im_a[2] = 16'h2011;
    im_a[3] = 16'hF000;
    dm_a[12'h010] = 16'd7;
  endtask

  task automatic test_program();
    int cyc;
    load_basic();
    run_a(0, 0, 0, 200, cyc);
    tests++;
    if (cyc !== 11 || halt_a !== 1'b1) begin
      fails++;
      $display("FAIL halt_latency: got %0d/%b want 11/1",
               cyc, halt_a);
    end
    tests++;
    if (dm_a[12'h011] !== 16'd12) begin
      fails++;
      $display("FAIL sta_result: got %h want 000c",
               dm_a[12'h011]);
    end
    tests++;
    if (pc_a !== 12'd3 || acc_a !== 16'd12) begin
      fails++;
      $display("FAIL halt_pc_acc: got %h/%h want 003/000c",
               pc_a, acc_a);
    end
  endtask

  task automatic test_sub_borrow();
    int cyc;
    clear_a();
    im_a[0] = 16'hD003;
    im_a[1] = 16'h4020;
    im_a[2] = 16'hB040;
    dm_a[12'h020] = 16'd5;
    run_a(0, 0, 0, 200, cyc);
    tests++;
    if (acc_a !== 16'hFFFE || c_a !== 1'b1 ||
        z_a !== 1'b0) begin
      fails++;
      $display("FAIL sub_borrow: got %h c%b z%b want fffe c1 z0",
               acc_a, c_a, z_a);
    end
    tests++;
    if (pc_a !== 12'd3) begin
      fails++;
      $display("FAIL jz_not_taken: got %h want 003", pc_a);
    end
  endtask

  task automatic test_shift();
    int cyc;
    clear_a();
    im_a[0] = 16'h1030;
    im_a[1] = 16'h8000;
    dm_a[12'h030] = 16'h8001;
    run_a(0, 0, 0, 200, cyc);
    tests++;
    if (acc_a !== 16'h0002 || c_a !== 1'b1) begin
      fails++;
      $display("FAIL shl: got %h c%b want 0002 c1",
               acc_a, c_a);
    end
    im_a[1] = 16'h9000;
    run_a(0, 0, 0, 200, cyc);
    tests++;
    if (acc_a !== 16'h4000 || c_a !== 1'b1 ||
        z_a !== 1'b0) begin
      fails++;
      $display("FAIL shr: got %h c%b z%b want 4000 c1 z0",
               acc_a, c_a, z_a);
    end
  endtask

  task automatic test_wait_states();
    int cyc, mcyc;
    logic [15:0] macc;
    logic [11:0] mpc;
    logic mz, mc;
    load_basic();
    for (int i = 0; i < 4096; i++) mm[i] = dm_a[i];
    model_run(3, 2, macc, mpc, mz, mc, mcyc);
    run_a(3, 2, 1, 400, cyc);
    tests++;
    if (cyc !== mcyc) begin
      fails++;
      $display("FAIL wait_latency: got %0d want %0d",
               cyc, mcyc);
    end
    tests++;
    if (dm_a[12'h011] !== mm[12'h011]) begin
      fails++;
      $display("FAIL wait_mem: got %h want %h",
               dm_a[12'h011], mm[12'h011]);
    end
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL req_stable: got %0d changes want 0",
               viol);
    end
  endtask

  task automatic test_reset_mid_mem();
    int n;
    clear_a();
    im_a[0] = 16'hD055;
    im_a[1] = 16'h2020;
    start_a(0, 5, 0);
    n = 0;
    while (!(dreq_a && dwe_a) && n < 30) begin
      cycle_a();
      n++;
    end
    tests++;
    if (!(dreq_a && dwe_a)) begin
      fails++;
      $display("FAIL reach_sta: got %b want 1", dreq_a);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({dreq_a, dwe_a} !== 2'b00) begin
      fails++;
      $display("FAIL async_drop: got %b want 00",
               {dreq_a, dwe_a});
    end
    cycle_a();
    cycle_a();
    tests++;
    if (pc_a !== 12'd0 || acc_a !== 16'd0 ||
        dm_a[12'h020] !== 16'd0) begin
      fails++;
      $display("FAIL abandon: got %h/%h/%h want 0/0/0",
               pc_a, acc_a, dm_a[12'h020]);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ireq_a !== 1'b0) begin
      fails++;
      $display("FAIL reboot: got %b want 0", ireq_a);
    end
    cycle_a();
    tests++;
    if (ireq_a !== 1'b1) begin
      fails++;
      $display("FAIL refetch: got %b want 1", ireq_a);
    end
  endtask

  task automatic test_width8();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    tests++;
    if (halt_b !== 1'b1 || acc_b !== 8'h00 ||
        c_b !== 1'b1 || z_b !== 1'b1) begin
      fails++;
      $display("FAIL w8_add: got h%b %h c%b z%b want h1 00 c1 z1",
               halt_b, acc_b, c_b, z_b);
    end
    tests++;
    if (pc_b !== 8'h20) begin
      fails++;
      $display("FAIL w8_jc: got %h want 20", pc_b);
    end
  endtask

  task automatic test_wrap();
    int wraps, bad;
    logic [3:0] last;
    logic have;
    wraps = 0; bad = 0; have = 1'b0; last = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (ireq_c) begin
        if (have && iaddr_c !== last + 4'd1) bad++;
        if (have && last == 4'd15 && iaddr_c == 4'd0)
          wraps++;
        last = iaddr_c;
        have = 1'b1;
      end
    end
    tests++;
    if (wraps < 1 || bad != 0) begin
      fails++;
      $display("FAIL pc_wrap: got %0d wraps %0d bad want >=1/0",
               wraps, bad);
    end
  endtask

  task automatic test_random();
    int cyc, mcyc, iw, dw, diff;
    logic [15:0] macc;
    logic [11:0] mpc, opd;
    logic [3:0]  op;
    logic mz, mc;
    for (int t = 0; t < 8; t++) begin
      clear_a();
      for (int i = 0; i < 16; i++)
        dm_a[12'h100 + i] = 16'($urandom);
      for (int i = 0; i < 23; i++) begin
        op = 4'($urandom % 16);
        if (op == 4'hA || op == 4'hF) op = 4'h0;
        if (op == 4'hB || op == 4'hC) opd = 12'(i + 2);
        else if (op >= 4'h1 && op <= 4'h7)
          opd = 12'h100 + 12'($urandom % 16);
        else opd = 12'($urandom);
        im_a[i] = {op, opd};
      end
      for (int i = 0; i < 4096; i++) mm[i] = dm_a[i];
      iw = int'($urandom % 4);
      dw = int'($urandom % 3);
      model_run(iw, dw, macc, mpc, mz, mc, mcyc);
      run_a(iw, dw, 1, 2000, cyc);
      tests++;
      if ({acc_a, pc_a, z_a, c_a} !== {macc, mpc, mz, mc}) begin
        fails++;
        $display("FAIL rnd%0d_state: got %h want %h", t,
                 {acc_a, pc_a, z_a, c_a}, {macc, mpc, mz, mc});
      end
      tests++;
      if (cyc !== mcyc) begin
        fails++;
        $display("FAIL rnd%0d_cycles: got %0d want %0d",
                 t, cyc, mcyc);
      end
      diff = 0;
      for (int i = 0; i < 16; i++)
        if (dm_a[12'h100 + i] !== mm[12'h100 + i]) diff++;
      tests++;
      if (diff != 0 || viol != 0) begin
        fails++;
        $display("FAIL rnd%0d_mem: got %0d diffs %0d unstable want 0/0",
                 t, diff, viol);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      im_b[i] = 12'hF00;
      dm_b[i] = 8'h00;
    end
    im_b[0] = 12'hDFF;
    im_b[1] = 12'h310;
    im_b[2] = 12'hC20;
    dm_b[8'h10] = 8'h01;
    ia = 1'b0; da = 1'b0;
    iwait = 0; dwait = 0; spur = 0;
    icnt = 0; dcnt = 0; viol = 0;
    pireq = 1'b0; pdreq = 1'b0;
    piaddr = '0; pdv = '0;
    test_reset();
    test_program();
    test_sub_borrow();
    test_shift();
    test_wait_states();
    test_reset_mid_mem();
    test_width8();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
